// File: rtl/j68_pkg.sv
// j68_pkg: shared encodings for the j68 shift sequencer and ALU control
package j68_pkg;
  localparam logic [2:0] SH_ASL  = 3'd0;
  localparam logic [2:0] SH_ASR  = 3'd1;
  localparam logic [2:0] SH_LSL  = 3'd2;
  localparam logic [2:0] SH_LSR  = 3'd3;
  localparam logic [2:0] SH_ROL  = 3'd4;
  localparam logic [2:0] SH_ROR  = 3'd5;
  localparam logic [2:0] SH_ROXL = 3'd6;
  localparam logic [2:0] SH_ROXR = 3'd7;
  localparam logic [4:0] ALU_LSH = 5'b01000;
  localparam logic [4:0] ALU_RSH = 5'b01100;
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_W = 2'b01;
  localparam logic [1:0] SZ_L = 2'b10;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} seq_state_t;
endpackage

// File: rtl/j68_shift_flag.sv
// j68_shift_flag: size-dependent msb taps plus carry-in and shifted-out bit selection
module j68_shift_flag
  import j68_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  size,
  input  logic [31:0] val,
  input  logic        xr,
  output logic        msb,
  output logic        nmsb,
  output logic        cin,
  output logic        sout
);
  always_comb begin
    msb  = size == SZ_B ? val[7] : size == SZ_W ? val[15] : val[31];
    nmsb = size == SZ_B ? val[6] : size == SZ_W ? val[14] : val[30];
    sout = op[0] ? val[0] : msb;
    cin  = (op == SH_ASR || op == SH_ROL) ? msb :
           op == SH_ROR ? val[0] :
           (op == SH_ROXL || op == SH_ROXR) ? xr : 1'b0;
  end
endmodule

// File: rtl/j68_shift_seq.sv
// j68_shift_seq: steps the shared ALU one bit per enabled clock for 68000 shifts/rotates
module j68_shift_seq
  import j68_pkg::*;
#(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_ena,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [1:0]       size,
  input  logic [CNT_W-1:0] count,
  input  logic [31:0]      operand,
  input  logic             x_in,
  input  logic [31:0]      alu_result,
  output logic             busy,
  output logic [4:0]       alu_c,
  output logic [1:0]       alu_size,
  output logic [15:0]      alu_a,
  output logic [15:0]      alu_b,
  output logic             alu_cin,
  output logic             done,
  output logic [31:0]      result,
  output logic             c_out,
  output logic             x_out,
  output logic             v_out
);
  seq_state_t       state;
  logic [31:0]      opr;
  logic [2:0]       op_r;
  logic [CNT_W-1:0] cnt;
  logic             xr, cr, vs;
  logic             msb, nmsb, cin, sout;

  j68_shift_flag u_flag (
    .op   (op_r),
    .size (alu_size),
    .val  (opr),
    .xr   (xr),
    .msb  (msb),
    .nmsb (nmsb),
    .cin  (cin),
    .sout (sout)
  );

  assign busy    = state != S_IDLE;
  assign done    = state == S_FIN;
  assign alu_a   = opr[15:0];
  assign alu_b   = opr[31:16];
  assign alu_c   = state == S_RUN ? (op_r[0] ? ALU_RSH : ALU_LSH) : 5'b0;
  assign alu_cin = state == S_RUN && cin;
  assign result  = opr;
  assign c_out   = cr;
  assign x_out   = xr;
  assign v_out   = vs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      opr      <= '0;
      op_r     <= '0;
      alu_size <= '0;
      cnt      <= '0;
      xr       <= 1'b0;
      cr       <= 1'b0;
      vs       <= 1'b0;
    end else if (clk_ena) begin
      case (state)
        S_IDLE: if (start) begin
          opr      <= operand;
          op_r     <= op;
          alu_size <= size;
          cnt      <= count;
          xr       <= x_in;
          cr       <= (op == SH_ROXL || op == SH_ROXR) && x_in;
          vs       <= 1'b0;
          state    <= count != '0 ? S_RUN : S_FIN;
        end
        S_RUN: begin
          opr <= alu_result;
          cr  <= sout;
          if (op_r != SH_ROL && op_r != SH_ROR) xr <= sout;
          if (op_r == SH_ASL) vs <= vs | (msb ^ nmsb);
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) state <= S_FIN;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_j68_shift_seq.sv
// tb_j68_shift_seq: directed vectors against a behavioural model of the j68 ALU shifter
module tb_j68_shift_seq;
  import j68_pkg::*;

  logic        clk = 0, rst_n = 0, clk_ena = 1, start = 0, x_in = 0;
  logic [2:0]  op = 0;
  logic [1:0]  size = 0;
  logic [5:0]  count = 0;
  logic [31:0] operand = 0, alu_result;
  logic        busy, alu_cin, done, c_out, x_out, v_out;
  logic [4:0]  alu_c;
  logic [1:0]  alu_size;
  logic [15:0] alu_a, alu_b;
  logic [31:0] result;
  int n_cmp = 0, n_err = 0;

  j68_shift_seq #(.CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .clk_ena(clk_ena), .start(start), .op(op), .size(size),
    .count(count), .operand(operand), .x_in(x_in), .alu_result(alu_result), .busy(busy),
    .alu_c(alu_c), .alu_size(alu_size), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
    .done(done), .result(result), .c_out(c_out), .x_out(x_out), .v_out(v_out)
  );

  always #5 clk = ~clk;

  // Single-bit shifter of the shared ALU; unaffected upper bits pass through
  logic [31:0] av;
  always_comb begin
    av = {alu_b, alu_a};
    alu_result = av;
    if (alu_c == 5'b01000)
      alu_result = alu_size[1] ? {av[30:0], alu_cin} :
                   alu_size[0] ? {av[31:16], av[14:0], alu_cin} : {av[31:8], av[6:0], alu_cin};
    else if (alu_c == 5'b01100)
      alu_result = alu_size[1] ? {alu_cin, av[31:1]} :
                   alu_size[0] ? {av[31:16], alu_cin, av[15:1]} : {av[31:8], alu_cin, av[7:1]};
  end

  typedef struct {
    logic [2:0]  op;
    logic [1:0]  size;
    logic [5:0]  count;
    logic [31:0] operand;
    logic        x_in;
    logic [31:0] res;
    logic        c, x, v;
    int          lat;
  } vec_t;
  vec_t vt[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run(input vec_t v, input string nm);
    int n = 0;
    op = v.op; size = v.size; count = v.count; operand = v.operand; x_in = v.x_in; start = 1;
    do begin
      @(posedge clk); #1;
      start = 0;
      n++;
    end while (!done && n < 200);
    chk({nm, " latency"}, n, v.lat);
    chk({nm, " result"}, result, v.res);
    chk({nm, " c"}, c_out, v.c);
    chk({nm, " x"}, x_out, v.x);
    chk({nm, " v"}, v_out, v.v);
    @(posedge clk); #1;
    chk({nm, " done drop"}, {busy, done}, 2'b00);
  endtask

  initial begin
    int k;
    vt[0] = '{SH_ROL,  SZ_B, 6'd3,  32'h000000A5, 1, 32'h0000002D, 1, 1, 0, 4};
    vt[1] = '{SH_LSR,  SZ_W, 6'd4,  32'h12348001, 1, 32'h12340800, 0, 0, 0, 5};
    vt[2] = '{SH_ASL,  SZ_L, 6'd1,  32'h40000000, 1, 32'h80000000, 0, 0, 1, 2};
    vt[3] = '{SH_ASR,  SZ_B, 6'd2,  32'h00000080, 1, 32'h000000E0, 0, 0, 0, 3};
    vt[4] = '{SH_ROXR, SZ_L, 6'd0,  32'h13579BDF, 1, 32'h13579BDF, 1, 1, 0, 1};
    vt[5] = '{SH_ROXL, SZ_B, 6'd1,  32'hFFFFFF80, 0, 32'hFFFFFF00, 1, 1, 0, 2};
    vt[6] = '{SH_ROR,  SZ_W, 6'd5,  32'hABCD0001, 1, 32'hABCD0800, 0, 1, 0, 6};
    vt[7] = '{SH_ASL,  SZ_B, 6'd63, 32'h12345601, 0, 32'h12345600, 0, 0, 1, 64};
    vt[8] = '{SH_LSL,  SZ_L, 6'd2,  32'hC0000001, 0, 32'h00000004, 1, 1, 0, 3};
    vt[9] = '{SH_ROXR, SZ_W, 6'd1,  32'h00000002, 1, 32'h00008001, 0, 0, 0, 2};

    #12;
    chk("reset outs", {busy, done, alu_cin, c_out, x_out, v_out}, 6'b0);
    chk("reset data", {result, alu_a, alu_b}, 64'b0);
    chk("reset ctl", {alu_c, alu_size}, 7'b0);
    rst_n = 1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) run(vt[i], $sformatf("vec%0d", i));

    // Gated enable: edge k is enabled when k is even, start on edge 0
    op = SH_ROR; size = SZ_W; count = 6'd5; operand = 32'hABCD0001; x_in = 1; start = 1; clk_ena = 1;
    k = -1;
    do begin
      @(posedge clk); #1;
      k++;
      start = 0;
      if (k == 0) chk("gated alu_c", alu_c, ALU_RSH);
      if (!done) clk_ena = ((k + 1) % 2) == 0;
    end while (!done && k < 100);
    chk("gated done edge", k, 10);
    chk("gated result", result, 32'hABCD0800);
    chk("gated flags", {c_out, x_out, v_out}, 3'b010);
    clk_ena = 0;
    @(posedge clk); #1;
    chk("gated done held", {busy, done}, 2'b11);
    clk_ena = 1;
    @(posedge clk); #1;
    chk("gated done drop", {busy, done}, 2'b00);

    // Start while busy must be ignored
    op = SH_LSL; size = SZ_L; count = 6'd3; operand = 32'h00000001; x_in = 0; start = 1;
    k = 0;
    do begin
      @(posedge clk); #1;
      k++;
      start = 0;
      if (k == 1) chk("busy alu_ctl", {alu_c, alu_size, alu_cin}, {ALU_LSH, SZ_L, 1'b0});
      if (k == 2) begin
        start = 1; op = SH_ROR; count = 6'd0; operand = 32'hFFFFFFFF; x_in = 1;
      end
    end while (!done && k < 200);
    chk("ignore latency", k, 4);
    chk("ignore result", result, 32'h00000008);
    chk("ignore flags", {c_out, x_out, v_out}, 3'b000);
    @(posedge clk); #1;
    chk("ignore idle", {busy, done}, 2'b00);

    // Asynchronous reset in the middle of a run
    op = SH_LSL; size = SZ_L; count = 6'd10; operand = 32'hFFFFFFFF; x_in = 0; start = 1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      start = 0;
    end
    chk("pre-reset busy", {busy, c_out, x_out}, 3'b111);
    #2 rst_n = 0;
    #1;
    chk("abort outs", {busy, done, c_out, x_out, v_out}, 5'b0);
    chk("abort data", {result, alu_c}, 37'b0);
    @(posedge clk); #1;
    chk("abort no done", done, 1'b0);
    rst_n = 1;
    @(posedge clk); #1;
    run(vt[2], "post-reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
